// File: rtl/vending_pkg.sv
// Shared types and coin constants for the multi-product vending machine.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_e;

  localparam int unsigned NICKEL_VAL  = 1;
  localparam int unsigned DIME_VAL    = 2;
  localparam int unsigned QUARTER_VAL = 5;

  function automatic int unsigned coin_value(coin_e coin);
    unique case (coin)
      COIN_NICKEL:  return NICKEL_VAL;
      COIN_DIME:    return DIME_VAL;
      COIN_QUARTER: return QUARTER_VAL;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy change selector: picks the largest coin not exceeding the credit.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [1:0]          coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  coin_e coin;

  always_comb begin
    coin = COIN_NONE;
    if (credit_i >= CREDIT_W'(QUARTER_VAL)) begin
      coin = COIN_QUARTER;
    end else if (credit_i >= CREDIT_W'(DIME_VAL)) begin
      coin = COIN_DIME;
    end else if (credit_i >= CREDIT_W'(NICKEL_VAL)) begin
      coin = COIN_NICKEL;
    end
  end

  assign coin_o  = coin;
  assign value_o = CREDIT_W'(coin_value(coin));

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin credit, per-item stock, greedy change/refund.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned PRICE_W     = 5,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] ITEM_PRICES = {5'd7, 5'd5, 5'd4, 5'd3},
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned MAX_CREDIT  = 20,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_INIT  = 8,
  localparam int unsigned SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 nickel_i,
  input  logic                 dime_i,
  input  logic                 quarter_i,
  input  logic                 sel_valid_i,
  input  logic [SEL_W-1:0]     sel_item_i,
  input  logic                 cancel_i,
  input  logic                 restock_i,
  output logic [CREDIT_W-1:0]  credit_o,
  output logic                 vend_o,
  output logic [SEL_W-1:0]     vend_item_o,
  output logic                 sel_nack_o,
  output logic                 coin_reject_o,
  output logic                 change_valid_o,
  output logic [1:0]           change_coin_o,
  output logic [NUM_ITEMS-1:0] sold_out_o,
  output logic                 busy_o
);

  typedef logic [CREDIT_W:0] cext_t;

  state_e                            state_q, state_d;
  logic [CREDIT_W-1:0]               credit_q, credit_d;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;
  logic                              vend_q, vend_d;
  logic [SEL_W-1:0]                  vend_item_q, vend_item_d;
  logic                              sel_nack_q, sel_nack_d;
  logic                              coin_reject_q, coin_reject_d;
  logic                              change_valid_q, change_valid_d;
  logic [1:0]                        change_coin_q, change_coin_d;
  logic                              busy_q, busy_d;

  logic                coin_any, coin_multi, coin_fits;
  cext_t               coin_val;
  logic [PRICE_W-1:0]  sel_price;
  logic                sel_in_range, sel_in_stock, sel_ok;
  logic                in_front, cancel_act, sel_act, accept, coin_act;
  logic [1:0]          disp_coin;
  logic [CREDIT_W-1:0] disp_value;

  change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_change_dispenser (
    .credit_i (credit_q),
    .coin_o   (disp_coin),
    .value_o  (disp_value)
  );

  // Input decode shared by the next-state and output processes.
  always_comb begin
    coin_any   = nickel_i | dime_i | quarter_i;
    coin_multi = (nickel_i & dime_i) | (nickel_i & quarter_i) | (dime_i & quarter_i);
    coin_val   = '0;
    if (quarter_i) begin
      coin_val = cext_t'(QUARTER_VAL);
    end else if (dime_i) begin
      coin_val = cext_t'(DIME_VAL);
    end else if (nickel_i) begin
      coin_val = cext_t'(NICKEL_VAL);
    end
    coin_fits = (cext_t'(credit_q) + coin_val) <= cext_t'(MAX_CREDIT);

    sel_in_range = 32'(sel_item_i) < NUM_ITEMS;
    sel_price    = '0;
    sel_in_stock = 1'b0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (32'(sel_item_i) == i) begin
        sel_price    = ITEM_PRICES[i*PRICE_W +: PRICE_W];
        sel_in_stock = stock_q[i] != '0;
      end
    end
    sel_ok = sel_in_range & sel_in_stock & (cext_t'(credit_q) >= cext_t'(sel_price));

    in_front   = (state_q == IDLE) || (state_q == COLLECT);
    cancel_act = (state_q == COLLECT) && cancel_i;
    sel_act    = in_front && !cancel_act && sel_valid_i;
    accept     = sel_act && sel_ok;
    coin_act   = in_front && !cancel_act && !sel_valid_i && coin_any && !coin_multi && coin_fits;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      stock_q        <= {NUM_ITEMS{STOCK_W'(STOCK_INIT)}};
      vend_q         <= 1'b0;
      vend_item_q    <= '0;
      sel_nack_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= COIN_NONE;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      vend_q         <= vend_d;
      vend_item_q    <= vend_item_d;
      sel_nack_q     <= sel_nack_d;
      coin_reject_q  <= coin_reject_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (cancel_act) begin
          state_d = CHANGE;
        end else if (accept) begin
          state_d  = VEND;
          credit_d = credit_q - CREDIT_W'(sel_price);
          for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (32'(sel_item_i) == i) begin
              stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
          end
        end else if (coin_act) begin
          state_d  = COLLECT;
          credit_d = credit_q + CREDIT_W'(coin_val);
        end
      end
      VEND: begin
        state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        // Leave as the last coin goes out so IDLE coincides with credit reaching 0.
        credit_d = credit_q - disp_value;
        state_d  = (credit_q == disp_value) ? IDLE : CHANGE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    if (restock_i) begin
      stock_d = {NUM_ITEMS{STOCK_W'(STOCK_INIT)}};
    end
  end

  always_comb begin
    vend_d         = accept;
    vend_item_d    = accept ? sel_item_i : vend_item_q;
    sel_nack_d     = sel_act && !accept;
    coin_reject_d  = coin_any && !coin_act;
    change_valid_d = (state_q == CHANGE) && (credit_q != '0);
    change_coin_d  = change_valid_d ? disp_coin : COIN_NONE;
    busy_d         = (state_d == VEND) || (state_d == CHANGE);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      sold_out_o[i] = stock_q[i] == '0;
    end
  end

  assign credit_o       = credit_q;
  assign vend_o         = vend_q;
  assign vend_item_o    = vend_item_q;
  assign sel_nack_o     = sel_nack_q;
  assign coin_reject_o  = coin_reject_q;
  assign change_valid_o = change_valid_q;
  assign change_coin_o  = change_coin_q;
  assign busy_o         = busy_q;

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product vending machine.
- Accepts nickel, dime and quarter coins and accumulates credit up to a cap.
- Sells one of NUM_ITEMS products, each with its own price and stock counter.
- Returns change, or a refund on cancel, one coin per cycle using greedy quarter/dime/nickel order.

Parameters:
- NUM_ITEMS, 4, number of selectable products (>=1).
- PRICE_W, 5, width of one price field, in nickel units.
- ITEM_PRICES, {5'd7,5'd5,5'd4,5'd3}, packed prices in nickels; item i at bits [i*PRICE_W +: PRICE_W]; default is 15c, 20c, 25c, 35c.
- CREDIT_W, 6, credit register width, in nickel units.
- MAX_CREDIT, 20, credit cap in nickels (100c); must be < 2**CREDIT_W.
- STOCK_W, 4, width of each stock counter.
- STOCK_INIT, 8, stock loaded at reset and on restock.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- nickel  in  1  5c coin present this cycle.
- dime  in  1  10c coin present this cycle.
- quarter  in  1  25c coin present this cycle.
- sel_valid  in  1  product selection strobe.
- sel_item  in  $clog2(NUM_ITEMS) (min 1)  selected product index.
- cancel  in  1  refund request.
- restock  in  1  reload all stock counters.
- credit  out  CREDIT_W  current credit, in nickels.
- vend  out  1  one-cycle dispense pulse.
- vend_item  out  $clog2(NUM_ITEMS)  product dispensed; valid while vend=1.
- sel_nack  out  1  one-cycle pulse when a selection is refused.
- coin_reject  out  1  one-cycle pulse when a coin is returned uncredited.
- change_valid  out  1  a change coin is emitted this cycle.
- change_coin  out  2  coin emitted: 01 nickel, 10 dime, 11 quarter, 00 none.
- sold_out  out  NUM_ITEMS  bit i set when stock[i]==0.
- busy  out  1  high in VEND and CHANGE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Reset is sampled on posedge clk only and dominates all other inputs.
- Reset values: credit=0, vend=0, vend_item=0, sel_nack=0, coin_reject=0, change_valid=0, change_coin=00, busy=0, state=IDLE. Every stock counter = STOCK_INIT, so sold_out=0 when STOCK_INIT>0.
- Reset mid-operation: any pending credit or change is discarded. No change coins are emitted after reset.
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N (1-cycle latency).
- FSM states:
  - IDLE: credit==0.
  - COLLECT: credit>0, accepting coins and selections.
  - VEND: one cycle, vend=1.
  - CHANGE: emit coins until credit==0, then go to IDLE.
- Priority in IDLE/COLLECT: cancel > sel_valid > coin. A coin arriving in the same cycle as an accepted cancel or sel_valid is rejected (coin_reject=1).
- Coins:
  - Values are 1, 2 and 5 nickels.
  - If more than one coin line is high, none are credited and coin_reject pulses.
  - If credit+value > MAX_CREDIT, the coin is not credited and coin_reject pulses.
  - Otherwise credit += value, and IDLE moves to COLLECT.
- Selection:
  - Accepted only if sel_item < NUM_ITEMS, stock[sel_item] > 0 and credit >= price.
  - On acceptance, next cycle: state=VEND, vend=1, vend_item=sel_item, credit -= price, stock decremented.
  - On refusal: sel_nack pulses; credit and state are unchanged. sel_valid in IDLE (credit 0) is refused.
- After VEND: credit>0 goes to CHANGE; credit==0 goes to IDLE.
- Cancel in COLLECT goes to CHANGE with the full credit. Cancel in IDLE is ignored.
- CHANGE:
  - Each cycle emits one coin: quarter if credit>=5, else dime if credit>=2, else nickel. Credit is decremented by that coin's value.
  - change_valid=1 on each emission cycle.
  - The cycle after credit reaches 0, the FSM is in IDLE.
- In VEND/CHANGE: any coin is rejected (coin_reject pulses); sel_valid and cancel are ignored with no nack.
- Restock: reloads every counter to STOCK_INIT on the next edge, in any state. If it coincides with a decrement, restock wins.
- Stock counters saturate at 0; a decrement never occurs at 0, because selection is refused.
- Arithmetic: credit compare and add use CREDIT_W+1 bits; no wrap is possible under the cap.

Decomposition:
- Package vending_pkg:
  - coin_e enum {COIN_NONE=2'b00, COIN_NICKEL=2'b01, COIN_DIME=2'b10, COIN_QUARTER=2'b11}.
  - state_e enum {IDLE, COLLECT, VEND, CHANGE}.
  - Constants NICKEL_VAL=1, DIME_VAL=2, QUARTER_VAL=5.
- Sub-module change_dispenser:
  - Takes the current credit and returns the greedy coin choice and its value.
  - Purely combinational, reusable by the refund path.
- Top holds the FSM, credit register and stock array.

Test Plan:
- Reset, then dime, then nickel, then sel_item=0 (15c) -> credit 2, then 3; vend=1, vend_item=0; credit=0; no change_valid; FSM back to IDLE.
- Quarter, then sel_item=0 -> vend; credit=2 -> one change_valid with change_coin=10 (dime); credit=0; IDLE.
- Four quarters, then a fifth quarter -> credit=20 after four; fifth gives coin_reject=1, credit stays 20. Then cancel -> four quarter emissions, one per cycle.
- STOCK_INIT=1: buy item 3 twice with 35c each -> first vend; sold_out[3]=1. Second sel_nack=1, credit stays 7. Then restock -> sold_out[3]=0.
- Quarter+dime+nickel (credit 8), then cancel asserted together with a nickel -> nickel rejected; emits quarter, dime, nickel (11, 10, 01) on consecutive cycles.
- Dime with sel_item=1 (20c) and credit 2 -> sel_nack, dime rejected. Reset during CHANGE -> next cycle credit=0, change_valid=0, all stock=STOCK_INIT.
